// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory between two requesters
module mem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 12,
  parameter int COUNT      = 4096,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic {IDLE, RESP} state_t;
  state_t state, state_nx;
  logic ptr;
  logic any, win_we, win_ok, own, own_rd, own_err, v;
  logic [ADDR_W-1:0] win_addr, last_addr;
  logic [DATA_W-1:0] win_wdata, last_wdata;
  // ptr=1 means m1 is favoured on the next contended cycle
  always_comb begin
    m0_gnt    = !rst && m0_req && (!m1_req || (FIXED_PRIO == 0 && !ptr));
    m1_gnt    = !rst && m1_req && !m0_gnt;
    any       = m0_gnt || m1_gnt;
    win_we    = m1_gnt ? m1_we : m0_we;
    win_addr  = m1_gnt ? m1_addr : m0_addr;
    win_wdata = m1_gnt ? m1_wdata : m0_wdata;
    win_ok    = 32'(win_addr) < COUNT;
    mem_addr  = any ? win_addr : last_addr;
    mem_wdata = any ? win_wdata : last_wdata;
    mem_we    = any && win_we && win_ok;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= 1'b0;
      last_addr  <= '0;
      last_wdata <= '0;
      own        <= 1'b0;
      own_rd     <= 1'b0;
      own_err    <= 1'b0;
    end else if (any) begin
      ptr        <= m0_gnt;
      last_addr  <= win_addr;
      last_wdata <= win_wdata;
      own        <= m1_gnt;
      own_rd     <= !win_we;
      own_err    <= !win_ok;
    end
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb state_nx = any ? RESP : IDLE;
  // reset suppresses a response registered just before it
  always_comb begin
    v         = !rst && state == RESP;
    m0_rvalid = v && !own;
    m1_rvalid = v && own;
    m0_err    = m0_rvalid && own_err;
    m1_err    = m1_rvalid && own_err;
    m0_rdata  = (m0_rvalid && own_rd && !own_err) ? mem_rdata : '0;
    m1_rdata  = (m1_rvalid && own_rd && !own_err) ? mem_rdata : '0;
  end
endmodule
